sb_rx_deser: RTL and testbench
==============================

SB_RX_DESER -- requirements
Module: sb_rx_deser

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 4, receive-FIFO depth in 64-bit words; power of 2, >1.
REQ-002 SHALL have port clk_800MHz  input  1  sideband bit clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dataPin_i  input  1  serial sideband data, LSB first.
REQ-005 SHALL have port clkActive_i  input  1  forwarded-clock activity qualifier; 1 = link clock toggling, bit present this cycle.
REQ-006 SHALL have port enable_i  input  1  1 = completed words are written to the FIFO; 0 = completed words are discarded.
REQ-007 SHALL have port data_o  output  64  head-of-FIFO word.
REQ-008 SHALL have port valid_o  output  1  data_o holds a valid word.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-010 SHALL have port overflow_o  output  1  sticky; a completed word was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse on a framing violation.
REQ-012 SHALL have port rx_busy_o  output  1  1 while state != IDLE.

Function
REQ-013 SHALL implement states IDLE, RECEIVING and GAP.
REQ-014 In IDLE with clkActive_i=1, SHALL sample dataPin_i as bit 0, set bit counter to 1 and go to RECEIVING; the same edge counts as bit 0.
REQ-015 In RECEIVING with clkActive_i=1, SHALL store dataPin_i as bit[counter], using a 6-bit counter.
REQ-016 On the edge sampling bit 63, SHALL form the complete word (bits 0-62 plus the current bit), push it if enable_i=1 and the FIFO is not full, and go to GAP with gap counter 0.
REQ-017 GAP SHALL last exactly 32 cycles, counted by a 5-bit counter.
REQ-018 After the 32nd GAP cycle, if clkActive_i=1, SHALL take the next edge as bit 0 of a new word (enter RECEIVING); if clkActive_i=0, SHALL go to IDLE.
REQ-019 If clkActive_i=0 in RECEIVING, SHALL discard the partial word, pulse frame_err_o, clear counters and go to IDLE.
REQ-020 If clkActive_i=0 before gap cycle 32, SHALL pulse frame_err_o and go to IDLE; the already-delivered word is kept.
REQ-021 If dataPin_i=1 during GAP, SHALL pulse frame_err_o and continue the gap count.
REQ-022 Pushed-word latency: valid_o=1 in the cycle after the edge that sampled bit 63, when the FIFO was empty.
REQ-023 FIFO SHALL be first-word-fall-through, with read/write pointers of clog2(BUFFER_SIZE) bits wrapping modulo BUFFER_SIZE and an occupancy count of clog2(BUFFER_SIZE)+1 bits.
REQ-024 Push when full with no pop in the same cycle: word dropped, overflow_o set until reset, FIFO contents unchanged.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; in that case the push succeeds and no overflow is flagged.
REQ-026 Pop when empty SHALL be ignored.
REQ-027 With enable_i=0, completed words SHALL be discarded without setting overflow_o, and framing/state tracking SHALL continue.

Reset
REQ-028 On reset=1 at a clock edge, SHALL force IDLE, clear all counters, FIFO pointers and count, and the assembly register.
REQ-029 Reset values: data_o=0, valid_o=0, overflow_o=0, frame_err_o=0, rx_busy_o=0.
REQ-030 Reset mid-word SHALL drop the partial word, and reset SHALL take priority over every simultaneous event.

Structure
REQ-031 Sideband constants (SB_WORD_BITS=64, SB_GAP_CYCLES=32) and the rx_state_t enum SHALL live in the shared sideband package, which the transmit side also uses.
REQ-032 The FIFO SHALL be a sub-module sb_rx_fifo, parameterised by BUFFER_SIZE and WIDTH=64; the framing FSM stays in sb_rx_deser.

Verification
REQ-033 Single word: clkActive_i high 96 cycles, 64 bits of 64'hA5A5_0000_DEAD_BEEF LSB first, then 32 zeros, ready_i=1 -> valid_o pulses one cycle with that value in the cycle after bit 63, frame_err_o never set.
REQ-034 Back-to-back: 3 words (64'h1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF), 32-cycle gaps, clkActive_i continuously high -> three words out in order, rx_busy_o high throughout.
REQ-035 Overflow: ready_i=0, 5 words with BUFFER_SIZE=4 -> first 4 retained, overflow_o=1 after word 5; then ready_i=1 -> exactly 4 words drained, valid_o falls.
REQ-036 Truncation: clkActive_i drops after bit 40 -> frame_err_o single-cycle pulse, no word pushed, state IDLE; a following clean word 64'h1234 is received correctly.
REQ-037 Gap violation: dataPin_i=1 at gap cycle 10 -> frame_err_o pulse, the preceding word is still delivered, the next word is received normally.
REQ-038 Reset mid-word: reset at bit 20 -> all outputs 0 the next cycle, FIFO empty, a subsequent word is received correctly.

Source files
------------

// File: rtl/sb_rx_deser_pkg.sv
// ============================================================================
// Module : sb_rx_deser_pkg
// Desc   : Sideband link constants and receive-state encoding shared by RX/TX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sb_rx_deser_pkg;

   localparam int SB_WORD_BITS  = 64;
   localparam int SB_GAP_CYCLES = 32;

   localparam int SB_BIT_CNT_W  = $clog2(SB_WORD_BITS);
   localparam int SB_GAP_CNT_W  = $clog2(SB_GAP_CYCLES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RECEIVING = 2'd1,
      GAP       = 2'd2
   } rx_state_t;

endpackage : sb_rx_deser_pkg

`default_nettype wire

// File: rtl/sb_rx_fifo.sv
// ============================================================================
// Module : sb_rx_fifo
// Desc   : First-word-fall-through receive FIFO with sticky overflow flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_rx_fifo #(
   parameter int BUFFER_SIZE = 4,
   parameter int WIDTH       = 64
) (
   input  logic             clk_800MHz,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             overflow_o
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [BUFFER_SIZE];
   logic [WIDTH-1:0] mem_d [BUFFER_SIZE];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   logic empty;
   logic full;
   logic do_pop;
   logic do_push;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(BUFFER_SIZE));
   assign do_pop  = pop_i && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (push_i && !do_push) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_800MHz) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_800MHz) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
   assign valid_o    = !empty;
   assign overflow_o = overflow_q;

endmodule : sb_rx_fifo

`default_nettype wire

// File: rtl/sb_rx_deser.sv
// ============================================================================
// Module : sb_rx_deser
// Desc   : Sideband serial receiver: frames 64-bit words and queues them.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_rx_deser
   import sb_rx_deser_pkg::*;
#(
   parameter int BUFFER_SIZE = 4
) (
   input  logic                    clk_800MHz,
   input  logic                    reset,
   input  logic                    dataPin_i,
   input  logic                    clkActive_i,
   input  logic                    enable_i,
   output logic [SB_WORD_BITS-1:0] data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    overflow_o,
   output logic                    frame_err_o,
   output logic                    rx_busy_o
);

   localparam logic [SB_BIT_CNT_W-1:0] LAST_BIT = SB_BIT_CNT_W'(SB_WORD_BITS - 1);
   localparam logic [SB_GAP_CNT_W-1:0] LAST_GAP = SB_GAP_CNT_W'(SB_GAP_CYCLES - 1);

   rx_state_t                 state_q, state_d;
   logic [SB_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [SB_GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [SB_WORD_BITS-2:0]   shreg_q, shreg_d;
   logic                      frame_err_q, frame_err_d;

   logic                      push;
   logic [SB_WORD_BITS-1:0]   push_data;

   // Bit 63 is taken straight from the pin so the word is pushed on its own edge.
   assign push_data = {dataPin_i, shreg_q};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      push        = 1'b0;

      case (state_q)
         IDLE: begin
            if (clkActive_i) begin
               shreg_d[0] = dataPin_i;
               bit_cnt_d  = SB_BIT_CNT_W'(1);
               state_d    = RECEIVING;
            end
         end

         RECEIVING: begin
            if (!clkActive_i) begin
               // Counter at 0 means the gap just ended and no bit has arrived yet.
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               gap_cnt_d   = '0;
               shreg_d     = '0;
               state_d     = IDLE;
            end else if (bit_cnt_q == LAST_BIT) begin
               push      = enable_i;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               state_d   = GAP;
            end else begin
               shreg_d[bit_cnt_q] = dataPin_i;
               bit_cnt_d          = bit_cnt_q + 1'b1;
            end
         end

         GAP: begin
            if (!clkActive_i) begin
               frame_err_d = (gap_cnt_q != LAST_GAP);
               gap_cnt_d   = '0;
               state_d     = IDLE;
            end else begin
               frame_err_d = dataPin_i;
               if (gap_cnt_q == LAST_GAP) begin
                  gap_cnt_d = '0;
                  bit_cnt_d = '0;
                  state_d   = RECEIVING;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_800MHz) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
      end
   end

   sb_rx_fifo #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .WIDTH       (SB_WORD_BITS)
   ) u_fifo (
      .clk_800MHz  (clk_800MHz),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (ready_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .overflow_o  (overflow_o)
   );

   assign frame_err_o = frame_err_q;
   assign rx_busy_o   = (state_q != IDLE);

endmodule : sb_rx_deser

`default_nettype wire

// File: tb/tb_sb_rx_deser.sv
// ============================================================================
// Module : tb_sb_rx_deser
// Desc   : Scoreboard bench for sb_rx_deser with directed and random framing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sb_rx_deser;

   localparam int BUFFER_SIZE = 4;

   logic        clk_800MHz = 1'b0;
   logic        reset      = 1'b1;
   logic        data_pin   = 1'b0;
   logic        clk_active = 1'b0;
   logic        enable     = 1'b1;
   logic        ready      = 1'b1;
   logic [63:0] data_o;
   logic        valid_o;
   logic        overflow_o;
   logic        frame_err_o;
   logic        rx_busy_o;

   sb_rx_deser #(.BUFFER_SIZE(BUFFER_SIZE)) dut (
      .clk_800MHz  (clk_800MHz),
      .reset       (reset),
      .dataPin_i   (data_pin),
      .clkActive_i (clk_active),
      .enable_i    (enable),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready),
      .overflow_o  (overflow_o),
      .frame_err_o (frame_err_o),
      .rx_busy_o   (rx_busy_o)
   );

   always #5 clk_800MHz = ~clk_800MHz;

   logic [63:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          fe_seen     = 0;
   int          fe_exp      = 0;
   int          drained     = 0;
   bit          exp_ovf     = 1'b0;
   bit          rand_ready  = 1'b0;
   bit          watch_busy  = 1'b0;
   bit          busy_drop   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every accepted output word is compared with the scoreboard head.
   always @(negedge clk_800MHz) begin
      if (!reset) begin
         if (frame_err_o) fe_seen++;
         if (valid_o && ready) begin
            drained++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got %h expected none", data_o);
            end else begin
               chk("word", data_o, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_800MHz);
      #1;
   endtask

   task automatic drive_bit(input logic act, input logic pin);
      clk_active = act;
      data_pin   = pin;
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      tick();
      if (watch_busy && !rx_busy_o) busy_drop = 1'b1;
   endtask

   task automatic send_bits(input logic [63:0] w, input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1, w[i]);
   endtask

   // Reference: a completed word is kept when enabled and fewer than BUFFER_SIZE
   // words are waiting; otherwise an enabled word is lost and overflow sticks.
   task automatic send_word(input logic [63:0] w);
      send_bits(w, 63);
      drive_bit(1'b1, w[63]);
      if (enable) begin
         if (exp_q.size() < BUFFER_SIZE) exp_q.push_back(w);
         else exp_ovf = 1'b1;
      end
   endtask

   task automatic gap(input int err_at);
      for (int g = 0; g < 32; g++) drive_bit(1'b1, g == err_at);
      if (err_at >= 0 && err_at < 32) fe_exp++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] w;
      int          mode;
      int          k;

      // Reset values
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_data", data_o, 64'h0);
      chk("rst_valid", valid_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_frame_err", frame_err_o, 0);
      chk("rst_busy", rx_busy_o, 0);
      reset = 1'b0;
      tick();

      // Single word: valid one cycle after bit 63, one-cycle pulse
      ready = 1'b1;
      send_word(64'hA5A5_0000_DEAD_BEEF);
      chk("single_valid", valid_o, 1);
      chk("single_data", data_o, 64'hA5A5_0000_DEAD_BEEF);
      drive_bit(1'b1, 1'b0);
      chk("single_pulse", valid_o, 0);
      for (int g = 1; g < 32; g++) drive_bit(1'b1, 1'b0);
      idle(2);
      chk("single_frame_err", fe_seen, 0);
      chk("single_idle", rx_busy_o, 0);

      // Back-to-back words with rx_busy held high
      watch_busy = 1'b1;
      send_word(64'h1);
      gap(-1);
      send_word(64'h8000_0000_0000_0000);
      gap(-1);
      send_word(64'hFFFF_FFFF_FFFF_FFFF);
      gap(-1);
      watch_busy = 1'b0;
      idle(2);
      chk("b2b_busy_drop", busy_drop, 0);
      chk("b2b_frame_err", fe_seen, fe_exp);

      // Overflow: five words into a four-deep FIFO
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_word(64'h0100_0000_0000_0000 * (i + 1) + 64'(i * 3 + 7));
         if (i == 3) chk("ovf_before", overflow_o, 0);
         gap(-1);
      end
      idle(1);
      chk("ovf_after", overflow_o, exp_ovf);
      drained = 0;
      ready   = 1'b1;
      for (int t = 0; t < 12; t++) tick();
      chk("ovf_drained", drained, 4);
      chk("ovf_valid_low", valid_o, 0);

      // Truncation after bit 40
      send_bits(64'hFEDC_BA98_7654_3210, 41);
      drive_bit(1'b0, 1'b0);
      fe_exp++;
      chk("trunc_pulse", frame_err_o, 1);
      chk("trunc_idle", rx_busy_o, 0);
      drive_bit(1'b0, 1'b0);
      chk("trunc_pulse_end", frame_err_o, 0);
      send_word(64'h1234);
      gap(-1);
      idle(2);
      chk("trunc_frame_err", fe_seen, fe_exp);

      // Gap violation at gap cycle 10
      send_word(64'h0BAD_F00D_CAFE_0001);
      gap(10);
      send_word(64'h5555_AAAA_3333_CCCC);
      gap(-1);
      idle(2);
      chk("gapviol_frame_err", fe_seen, fe_exp);

      // Reset mid-word with a word waiting in the FIFO
      ready = 1'b0;
      send_word(64'h7777_0000_1111_2222);
      gap(-1);
      send_bits(64'hDEAD_DEAD_DEAD_DEAD, 20);
      reset = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      tick();
      chk("midrst_data", data_o, 64'h0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_overflow", overflow_o, 0);
      chk("midrst_frame_err", frame_err_o, 0);
      chk("midrst_busy", rx_busy_o, 0);
      reset = 1'b0;
      ready = 1'b1;
      clk_active = 1'b0;
      tick();
      send_word(64'h0F0F_1234_5678_9ABC);
      gap(-1);
      idle(2);

      // Random framing, data, enable and consumer back-pressure
      rand_ready = 1'b1;
      for (int it = 0; it < 30; it++) begin
         mode   = $urandom_range(0, 9);
         enable = ($urandom_range(0, 3) != 0);
         w      = {$urandom(), $urandom()};
         if (mode <= 6) begin
            send_word(w);
            gap(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
         end else if (mode <= 8) begin
            k = $urandom_range(1, 63);
            send_bits(w, k);
            drive_bit(1'b0, 1'b0);
            fe_exp++;
         end else begin
            send_word(w);
            k = $urandom_range(0, 30);
            for (int j = 0; j < k; j++) drive_bit(1'b1, 1'b0);
            drive_bit(1'b0, 1'b0);
            fe_exp++;
         end
      end
      rand_ready = 1'b0;
      ready      = 1'b1;
      enable     = 1'b1;
      idle(12);
      chk("final_drain", exp_q.size(), 0);
      chk("final_frame_err", fe_seen, fe_exp);
      chk("final_overflow", overflow_o, exp_ovf);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sb_rx_deser

`default_nettype wire
